dut_frame_arbiter: RTL
======================

Name: dut_frame_arbiter

Overview:
Frame-based round-robin arbiter that shares one output interface between NUM_CH input channel controllers. It consumes each channel's registered valid/data/last signals and returns a per-channel transfer indication. Once a channel wins, it holds the output until its last word has been transferred, so frames are never interleaved. It sits between the bank of input channel controllers and the downstream processing stage, behind a single registered output stage.

Parameters:
NUM_CH, 4, number of input channels; legal values 2..16.
DATA_WIDTH, 8, data word width in bits.
CH_ID_WIDTH, $clog2(NUM_CH), width of the channel id; derived, must not be overridden.
CNT_WIDTH, 16, width of the completed-frame counter.

Ports:
clk  input  1  clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
first_cycle_of_proc_req  input  1  start-of-request pulse; restarts arbitration.
in_valid_arb  input  NUM_CH  per-channel valid, bit i = channel i.
in_data_arb  input  NUM_CH*DATA_WIDTH  per-channel data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
in_data_last_arb  input  NUM_CH  per-channel last-word-of-frame flag.
arb_in_transferring  output  NUM_CH  one-hot-or-zero; bit i high means channel i's word is accepted this cycle.
out_valid  output  1  output word valid.
out_ready  input  1  downstream ready.
out_data  output  DATA_WIDTH  output word.
out_data_last  output  1  last word of the frame.
out_ch_id  output  CH_ID_WIDTH  source channel of the output word.
frames_done  output  CNT_WIDTH  number of frames completed at the output; saturating.
VDD  input  1  power pin; no functional use.
VSS  input  1  ground pin; no functional use.

Behaviour:
- Reset (reset=1 at a clk edge) drives the following:
  - state=IDLE, rr_ptr=0, lock_ch=0.
  - out_valid=0, out_data=0, out_data_last=0, out_ch_id=0, frames_done=0.
  - arb_in_transferring=0 while reset is high.
- load_ok = !out_valid || out_ready. The output register accepts a new word only when load_ok is high.
- IDLE state:
  - cand = first channel i with in_valid_arb[i]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_CH.
  - If a candidate exists, load_ok=1 and first_cycle_of_proc_req=0, then arb_in_transferring[cand]=1 in the same cycle. Grant is combinational, with no bubble.
  - If the accepted word has last=0, go to LOCKED with lock_ch=cand.
  - If the accepted word has last=1 (single-word frame), stay in IDLE and set rr_ptr=(cand+1) mod NUM_CH.
  - If there is no candidate or load_ok=0, nothing is accepted and rr_ptr is unchanged.
- LOCKED state:
  - Only lock_ch may transfer: arb_in_transferring[lock_ch] = in_valid_arb[lock_ch] && load_ok && !first_cycle_of_proc_req.
  - Valids on other channels are ignored.
  - When a word with last=1 is accepted, go to IDLE and set rr_ptr=(lock_ch+1) mod NUM_CH.
- Output register:
  - On an accept, the next edge loads out_data, out_data_last and out_ch_id from the selected channel and sets out_valid=1.
  - If out_valid && out_ready with no accept, out_valid goes to 0 and data is held.
  - If out_valid=1 and out_ready=0, all outputs hold stable. The protocol requires this.
  - Accept-to-out_valid latency is 1 cycle. Sustained throughput is 1 word/cycle when out_ready stays high.
- frames_done:
  - Increments by 1 on each cycle with out_valid && out_ready && out_data_last.
  - Saturates at 2^CNT_WIDTH-1.
- first_cycle_of_proc_req=1 takes priority over everything except reset:
  - No accepts that cycle.
  - Next edge: state=IDLE, rr_ptr=0, out_valid=0, frames_done=0.
  - A pending output word is discarded; this holds even if a frame is mid-way in LOCKED.
- Simultaneous events:
  - An accept and an output drain in the same cycle (out_valid && out_ready && accept) loads the new word; out_valid stays 1.
  - The granting channel's last word and a request from the next channel arrive in the same cycle: the next channel is served no earlier than the following cycle, via the IDLE scan.
- Reset mid-frame aborts the frame with no output side effects after the reset edge.
- in_data_arb of non-granted channels must not affect any output.

Test Plan:
- Reset, then channel 2 sends a 3-word frame A0,A1,A2 with out_ready=1 -> arb_in_transferring=4'b0100 for 3 consecutive cycles; out_data = A0,A1,A2 one cycle later with out_ch_id=2; out_data_last only on A2; frames_done=1.
- Channels 0 and 1 are both valid with 2-word frames from rr_ptr=0 -> ch0 gets both words first, then ch1, with no interleaving; rr_ptr ends at 2; frames_done=2.
- LOCKED on ch1 while ch3 holds valid, out_ready=0 for 4 cycles -> arb_in_transferring=0 and outputs stable during the stall; ch1 resumes first after the stall; ch3 is granted only after ch1's last word.
- All 4 channels continuously send 1-word frames with out_ready=1 -> grant order 0,1,2,3,0,... with one word per cycle and no bubbles.
- first_cycle_of_proc_req asserted mid-frame on ch2 with out_valid=1 -> no grant that cycle; next cycle out_valid=0, frames_done=0, state IDLE, rr_ptr=0, so ch0 wins if valid.
- Preload frames_done to 0xFFFE via 0xFFFE completed frames (or a forced bench value), then complete 3 more frames -> frames_done=0xFFFF and held.

Source files
------------

// File: rtl/dut_frame_arbiter.sv
// Frame-based round-robin arbiter: NUM_CH channels share one registered output stage.
// A winning channel keeps the grant until its last word is accepted.
module dut_frame_arbiter #(
   parameter int NUM_CH      = 4,
   parameter int DATA_WIDTH  = 8,
   parameter int CH_ID_WIDTH = $clog2(NUM_CH),
   parameter int CNT_WIDTH   = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         first_cycle_of_proc_req,
   input  logic [NUM_CH-1:0]            in_valid_arb,
   input  logic [NUM_CH*DATA_WIDTH-1:0] in_data_arb,
   input  logic [NUM_CH-1:0]            in_data_last_arb,
   output logic [NUM_CH-1:0]            arb_in_transferring,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic                         out_data_last,
   output logic [CH_ID_WIDTH-1:0]       out_ch_id,
   output logic [CNT_WIDTH-1:0]         frames_done,
   input  logic                         VDD,
   input  logic                         VSS
);
   localparam int IDW = CH_ID_WIDTH + 1;

   typedef enum logic {S_IDLE, S_LOCKED} state_t;

   state_t                 state_q, state_d;
   logic [CH_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   logic [CH_ID_WIDTH-1:0] lock_ch_q, lock_ch_d;
   logic                   out_valid_q, out_valid_d;
   logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
   logic                   out_data_last_q, out_data_last_d;
   logic [CH_ID_WIDTH-1:0] out_ch_id_q, out_ch_id_d;
   logic [CNT_WIDTH-1:0]   frames_done_q, frames_done_d;

   logic                   load_ok, drain, cand_found, accept, sel_last;
   logic [CH_ID_WIDTH-1:0] cand, sel_ch, sel_next;
   logic [IDW-1:0]         scan_idx, next_idx;
   logic [DATA_WIDTH-1:0]  sel_data;
   logic                   unused_pwr;

   assign unused_pwr = VDD ^ VSS;
   assign load_ok    = !out_valid_q || out_ready;
   assign drain      = out_valid_q && out_ready;

   // Round-robin scan starting at rr_ptr, wrapping modulo NUM_CH.
   always_comb begin
      cand_found = 1'b0;
      cand       = '0;
      scan_idx   = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         scan_idx = {1'b0, rr_ptr_q} + IDW'(k);
         if (scan_idx >= IDW'(NUM_CH)) scan_idx = scan_idx - IDW'(NUM_CH);
         if (!cand_found && in_valid_arb[scan_idx[CH_ID_WIDTH-1:0]]) begin
            cand_found = 1'b1;
            cand       = scan_idx[CH_ID_WIDTH-1:0];
         end
      end
   end

   always_comb begin
      sel_ch   = (state_q == S_LOCKED) ? lock_ch_q : cand;
      accept   = 1'b0;
      sel_data = '0;
      sel_last = 1'b0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (sel_ch == CH_ID_WIDTH'(i)) begin
            sel_data = in_data_arb[i*DATA_WIDTH +: DATA_WIDTH];
            sel_last = in_data_last_arb[i];
         end
      end
      if (!reset && !first_cycle_of_proc_req && load_ok) begin
         if (state_q == S_LOCKED) accept = in_valid_arb[lock_ch_q];
         else                     accept = cand_found;
      end
      next_idx = {1'b0, sel_ch} + IDW'(1);
      if (next_idx >= IDW'(NUM_CH)) next_idx = '0;
      sel_next = next_idx[CH_ID_WIDTH-1:0];
      arb_in_transferring = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         arb_in_transferring[i] = accept && (sel_ch == CH_ID_WIDTH'(i));
      end
   end

   always_comb begin
      state_d         = state_q;
      rr_ptr_d        = rr_ptr_q;
      lock_ch_d       = lock_ch_q;
      out_valid_d     = out_valid_q;
      out_data_d      = out_data_q;
      out_data_last_d = out_data_last_q;
      out_ch_id_d     = out_ch_id_q;
      frames_done_d   = frames_done_q;
      if (first_cycle_of_proc_req) begin
         // Restart discards any pending word and an unfinished locked frame.
         state_d       = S_IDLE;
         rr_ptr_d      = '0;
         out_valid_d   = 1'b0;
         frames_done_d = '0;
      end else begin
         if (drain && out_data_last_q && (frames_done_q != '1))
            frames_done_d = frames_done_q + CNT_WIDTH'(1);
         if (accept) begin
            out_valid_d     = 1'b1;
            out_data_d      = sel_data;
            out_data_last_d = sel_last;
            out_ch_id_d     = sel_ch;
            if (sel_last) begin
               state_d  = S_IDLE;
               rr_ptr_d = sel_next;
            end else begin
               state_d   = S_LOCKED;
               lock_ch_d = sel_ch;
            end
         end else if (drain) begin
            out_valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= S_IDLE;
         rr_ptr_q        <= '0;
         lock_ch_q       <= '0;
         out_valid_q     <= 1'b0;
         out_data_q      <= '0;
         out_data_last_q <= 1'b0;
         out_ch_id_q     <= '0;
         frames_done_q   <= '0;
      end else begin
         state_q         <= state_d;
         rr_ptr_q        <= rr_ptr_d;
         lock_ch_q       <= lock_ch_d;
         out_valid_q     <= out_valid_d;
         out_data_q      <= out_data_d;
         out_data_last_q <= out_data_last_d;
         out_ch_id_q     <= out_ch_id_d;
         frames_done_q   <= frames_done_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign out_data      = out_data_q;
   assign out_data_last = out_data_last_q;
   assign out_ch_id     = out_ch_id_q;
   assign frames_done   = frames_done_q;

endmodule
